// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes and FSM state encoding for the multi-cycle ALU
// Purpose: opcode constants ALU_AND..ALU_DIVU and the controller state type.
// Ports: none (package).
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_XOR  = 4'd2;
    localparam logic [3:0] ALU_NOR  = 4'd3;
    localparam logic [3:0] ALU_ADD  = 4'd4;
    localparam logic [3:0] ALU_SUB  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_MULU = 4'd8;
    localparam logic [3:0] ALU_DIVU = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_mdu_iter.sv
// rtl/alu_mdu_iter.sv - shared shift-add multiply / restoring divide datapath
// Purpose: one multiply or divide step per cycle while step=1, WIDTH steps total.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load            capture a/b and mode, clear the step counter
//   step            advance one iteration
//   mode            0 = unsigned multiply, 1 = unsigned divide (sampled on load)
//   a, b            operands (multiplier/multiplicand or dividend/divisor)
//   last            the current step is the final one
//   res_lo, res_hi  value the shift register takes after the current step
//                   (low product/quotient, high product/remainder)
module alu_mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // acc holds the multiplicand or the divisor for the whole operation.
    logic [WIDTH-1:0]   acc;
    // sr = {partial product high / remainder, multiplier / quotient}
    logic [2*WIDTH-1:0] sr;
    logic [CNT_W-1:0]   cnt;
    logic               div_mode;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] sr_next;

    always_comb begin
        mul_sum = {1'b0, sr[2*WIDTH-1:WIDTH]} + (sr[0] ? {1'b0, acc} : '0);
        // Remainder shifted left with the next dividend bit; needs WIDTH+1 bits.
        rem_sh  = {sr[2*WIDTH-1:WIDTH], sr[WIDTH-1]};
        // Remainder stays below the divisor, so a set top bit means a borrow.
        trial   = rem_sh - {1'b0, acc};
        if (!div_mode) begin
            sr_next = {mul_sum, sr[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            sr_next = {trial[WIDTH-1:0], sr[WIDTH-2:0], 1'b1};
        end else begin
            sr_next = {rem_sh[WIDTH-1:0], sr[WIDTH-2:0], 1'b0};
        end
    end

    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign res_lo = sr_next[WIDTH-1:0];
    assign res_hi = sr_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            sr       <= '0;
            cnt      <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            acc      <= b;
            sr       <= {{WIDTH{1'b0}}, a};
            cnt      <= '0;
            div_mode <= mode;
        end else if (step) begin
            sr       <= sr_next;
            cnt      <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with start/busy/done handshake
// Purpose: single-cycle logic/arith ops plus iterative MULU/DIVU; results held until
//          the next accepted start.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        request, accepted only while busy=0
//   ALU_OP, A, B operation and operands, sampled with an accepted start
//   busy         operation in progress
//   done         one-cycle pulse when F/H/flags are updated
//   F, H         primary / secondary result
//   ZF, OF, DZ   zero, signed overflow (ADD/SUB), divide by zero (DIVU)
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  ALU_OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] H,
    output logic             ZF,
    output logic             OF,
    output logic             DZ
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;

    state_t           state;
    logic [OP_W-1:0]  op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    logic             accept;
    logic             iterative;
    logic             mdu_last;
    logic [WIDTH-1:0] mdu_lo;
    logic [WIDTH-1:0] mdu_hi;

    logic [WIDTH-1:0] s_f;
    logic [WIDTH-1:0] s_h;
    logic             s_of;
    logic             s_dz;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;

    assign accept    = start && (state == ST_IDLE || state == ST_DONE);
    // Divide by zero short-circuits to the single-cycle path.
    assign iterative = (ALU_OP == OP_W'(ALU_MULU)) ||
                       ((ALU_OP == OP_W'(ALU_DIVU)) && (B != '0));

    alu_mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (state == ST_ITER),
        .mode   (ALU_OP == OP_W'(ALU_DIVU)),
        .a      (A),
        .b      (B),
        .last   (mdu_last),
        .res_lo (mdu_lo),
        .res_hi (mdu_hi)
    );

    always_comb begin
        s_f  = '0;
        s_h  = '0;
        s_of = 1'b0;
        s_dz = 1'b0;
        sum  = a_r + b_r;
        dif  = a_r - b_r;
        case (op_r)
            OP_W'(ALU_AND):  s_f = a_r & b_r;
            OP_W'(ALU_OR):   s_f = a_r | b_r;
            OP_W'(ALU_XOR):  s_f = a_r ^ b_r;
            OP_W'(ALU_NOR):  s_f = ~(a_r | b_r);
            OP_W'(ALU_ADD): begin
                s_f  = sum;
                s_of = (a_r[MSB] == b_r[MSB]) && (sum[MSB] != a_r[MSB]);
            end
            OP_W'(ALU_SUB): begin
                // Same rule as ADD with B inverted: operand signs must differ.
                s_f  = dif;
                s_of = (a_r[MSB] != b_r[MSB]) && (dif[MSB] != a_r[MSB]);
            end
            OP_W'(ALU_SLTU): s_f = {{(WIDTH-1){1'b0}}, (a_r < b_r)};
            OP_W'(ALU_SLL):  s_f = b_r << a_r[SH_W-1:0];
            OP_W'(ALU_DIVU): begin
                // Only reached with B=0; non-zero divisors take the iterative path.
                s_f  = '1;
                s_h  = a_r;
                s_dz = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            F     <= '0;
            H     <= '0;
            ZF    <= 1'b0;
            OF    <= 1'b0;
            DZ    <= 1'b0;
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r  <= ALU_OP;
                        a_r   <= A;
                        b_r   <= B;
                        busy  <= 1'b1;
                        state <= iterative ? ST_ITER : ST_EXEC;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    F     <= s_f;
                    H     <= s_h;
                    ZF    <= (s_f == '0);
                    OF    <= s_of;
                    DZ    <= s_dz;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_DONE;
                end
                ST_ITER: begin
                    if (mdu_last) begin
                        F     <= mdu_lo;
                        H     <= mdu_hi;
                        ZF    <= (mdu_lo == '0);
                        OF    <= 1'b0;
                        DZ    <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc against a behavioural model
module tb_alu_mc;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    ALU_OP = '0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  F;
    logic [W-1:0]  H;
    logic          ZF;
    logic          OF;
    logic          DZ;

    int n_checks = 0;
    int n_pass   = 0;

    alu_mc #(.WIDTH(W), .OP_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ALU_OP (ALU_OP),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .F      (F),
        .H      (H),
        .ZF     (ZF),
        .OF     (OF),
        .DZ     (DZ)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] f;
        logic [W-1:0] h;
        logic         zf;
        logic         of;
        logic         dz;
        logic [7:0]   lat;
    } res_t;

    // Reference results straight from the arithmetic definition of each opcode.
    function automatic res_t calc(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t        r;
        longint      s;
        logic [63:0] p;
        r     = '0;
        r.lat = 8'd1;
        case (op)
            4'd0: r.f = a & b;
            4'd1: r.f = a | b;
            4'd2: r.f = a ^ b;
            4'd3: r.f = ~(a | b);
            4'd4: begin
                r.f  = a + b;
                s    = longint'($signed(a)) + longint'($signed(b));
                r.of = (s != longint'($signed(r.f)));
            end
            4'd5: begin
                r.f  = a - b;
                s    = longint'($signed(a)) - longint'($signed(b));
                r.of = (s != longint'($signed(r.f)));
            end
            4'd6: r.f = (a < b) ? 1 : 0;
            4'd7: r.f = b << (a % W);
            4'd8: begin
                p     = 64'(a) * 64'(b);
                r.f   = p[W-1:0];
                r.h   = p[2*W-1:W];
                r.lat = 8'(W);
            end
            4'd9: begin
                if (b == 0) begin
                    r.f  = '1;
                    r.h  = a;
                    r.dz = 1'b1;
                end else begin
                    r.f   = a / b;
                    r.h   = a % b;
                    r.lat = 8'(W);
                end
            end
            default: ;
        endcase
        r.zf = (r.f == 0);
        return r;
    endfunction

    // Transaction-level model: accept when idle, publish after the op's latency.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_f = '0;
    logic [W-1:0] m_h = '0;
    logic         m_zf = 1'b0;
    logic         m_of = 1'b0;
    logic         m_dz = 1'b0;
    logic [7:0]   m_el = '0;
    res_t         pend = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_f    <= '0;
            m_h    <= '0;
            m_zf   <= 1'b0;
            m_of   <= 1'b0;
            m_dz   <= 1'b0;
            m_el   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_el <= m_el + 8'd1;
                if (m_el + 8'd1 == pend.lat) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_f    <= pend.f;
                    m_h    <= pend.h;
                    m_zf   <= pend.zf;
                    m_of   <= pend.of;
                    m_dz   <= pend.dz;
                end
            end else if (start) begin
                pend   <= calc(ALU_OP, A, B);
                m_el   <= '0;
                m_busy <= 1'b1;
            end
        end
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    // Every cycle: the whole observable state must match the model.
    always @(negedge clk) begin
        check("cycle", {busy, done, ZF, OF, DZ, F, H}, {m_busy, m_done, m_zf, m_of, m_dz, m_f, m_h});
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start  = 1'b1;
        ALU_OP = op;
        A      = a;
        B      = b;
        @(posedge clk);
        #2;
        start  = 1'b0;
        ALU_OP = 4'($urandom);
        A      = $urandom;
        B      = $urandom;
    endtask

    task automatic do_start(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #2;
        issue(op, a, b);
    endtask

    // Returns at the negedge of the done cycle; lat counts edges after acceptance.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!done && lat < 100);
    endtask

    task automatic expect_res(input string nm, input int lat, input int elat,
                              input logic [W-1:0] ef, input logic [W-1:0] eh, input logic [2:0] efl);
        check($sformatf("%s_lat", nm), lat, elat);
        check($sformatf("%s_fh", nm), {F, H}, {ef, eh});
        check($sformatf("%s_flags", nm), {ZF, OF, DZ}, efl);
        check($sformatf("%s_model", nm), {m_f, m_h, m_zf, m_of, m_dz}, {ef, eh, efl});
    endtask

    task automatic run_op(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int elat, input logic [W-1:0] ef,
                          input logic [W-1:0] eh, input logic [2:0] efl);
        int lat;
        do_start(op, a, b);
        wait_done(lat);
        expect_res(nm, lat, elat, ef, eh, efl);
    endtask

    initial begin
        int lat;
        logic [3:0]   op;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) @(posedge clk);
        #2;
        check("reset_state", {busy, done, ZF, OF, DZ, F, H}, 128'd0);
        rst = 1'b0;

        run_op("add_ovf", 4'd4, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 32'h0, 3'b010);
        @(negedge clk);
        check("add_busy_after", busy, 1'b0);
        run_op("sub_zero", 4'd5, 32'd5, 32'd5, 1, 32'h0, 32'h0, 3'b100);
        run_op("sltu", 4'd6, 32'd3, 32'hFFFF_FFFF, 1, 32'h1, 32'h0, 3'b000);
        run_op("sll", 4'd7, 32'd33, 32'd1, 1, 32'h2, 32'h0, 3'b000);
        run_op("mulu_max", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, W, 32'h1, 32'hFFFF_FFFE, 3'b000);
        run_op("divu", 4'd9, 32'd100, 32'd7, W, 32'd14, 32'd2, 3'b000);
        run_op("divu_zero", 4'd9, 32'd9, 32'd0, 1, 32'hFFFF_FFFF, 32'd9, 3'b001);
        run_op("reserved", 4'd12, 32'h1234, 32'h5678, 1, 32'h0, 32'h0, 3'b100);

        // Start while busy is ignored.
        do_start(4'd8, 32'd3, 32'd5);
        repeat (5) @(posedge clk);
        #2;
        issue(4'd4, 32'd1, 32'd1);
        wait_done(lat);
        expect_res("mulu_ignore", lat, W - 6, 32'd15, 32'd0, 3'b000);
        // Back-to-back start in the done cycle.
        issue(4'd5, 32'd10, 32'd3);
        wait_done(lat);
        expect_res("b2b_sub", lat, 1, 32'd7, 32'd0, 3'b000);

        // Reset in the middle of a divide.
        do_start(4'd9, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_midop", {busy, done, ZF, OF, DZ, F, H}, 128'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        run_op("after_rst", 4'd4, 32'd2, 32'd3, 1, 32'd5, 32'd0, 3'b000);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) op = 4'($urandom_range(8, 9));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 3) == 0) ra = W'($urandom_range(0, 40));
            if ($urandom_range(0, 1) == 0) issue(op, ra, rb);
            else do_start(op, ra, rb);
            wait_done(lat);
            check("rand_lat", lat, 32'(calc(op, ra, rb).lat));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
